// File: rtl/fetch_pkg.sv
// Shared constants for the fetch PC-select controller: pc_sel codes, opcodes,
// BHT counter reset value and the saturating counter update.
package fetch_pkg;

    localparam logic [2:0] PC_SEL_PC4     = 3'd0;
    localparam logic [2:0] PC_SEL_BR_RES  = 3'd1;
    localparam logic [2:0] PC_SEL_JALR_X  = 3'd2;
    localparam logic [2:0] PC_SEL_BR_PRED = 3'd3;
    localparam logic [2:0] PC_SEL_JAL     = 3'd4;

    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    localparam logic [1:0] BHT_CTR_RESET = 2'b01;

    function automatic logic [1:0] bht_sat_next(input logic [1:0] ctr, input logic taken);
        logic [1:0] nxt;
        case ({taken, ctr})
            3'b1_11: nxt = 2'b11;
            3'b0_00: nxt = 2'b00;
            3'b1_00, 3'b1_01, 3'b1_10: nxt = ctr + 2'd1;
            3'b0_01, 3'b0_10, 3'b0_11: nxt = ctr - 2'd1;
            default: nxt = BHT_CTR_RESET;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/fetch_bht.sv
// Branch history table: 2-bit saturating counters, async read, sync update.
// Only compiled when FETCH_BHT_EN is defined.
`ifdef FETCH_BHT_EN
module fetch_bht
    import fetch_pkg::*;
#(
    parameter int IDX_BITS = 6
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [IDX_BITS-1:0] rd_idx_i,
    output logic [1:0]          rd_ctr_o,
    input  logic                wr_en_i,
    input  logic [IDX_BITS-1:0] wr_idx_i,
    input  logic                wr_taken_i
);

    localparam int ENTRIES = 1 << IDX_BITS;

    logic [1:0] ctr_q [ENTRIES];

    // Counter array; reset forces every entry to weakly not-taken.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                ctr_q[i] <= BHT_CTR_RESET;
            end
        end else if (wr_en_i) begin
            ctr_q[wr_idx_i] <= bht_sat_next(ctr_q[wr_idx_i], wr_taken_i);
        end
    end

    // Read returns the pre-update value when it hits the entry being written.
    assign rd_ctr_o = ctr_q[rd_idx_i];

endmodule
`endif

// File: rtl/fetch_pc_ctrl.sv
// Fetch-stage PC-select controller with optional BHT (macro FETCH_BHT_EN);
// without it prediction is static not-taken.
module fetch_pc_ctrl
    import fetch_pkg::*;
#(
    parameter int BHT_IDX_BITS = 6
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic [31:0] fd_inst,
    input  logic [31:0] fd_pc,
    input  logic        x_is_branch,
    input  logic        x_is_jalr,
    input  logic        x_br_taken,
    input  logic [31:0] x_pc,
    output logic [2:0]  pc_sel,
    output logic        br_pred_taken,
    output logic        mispredict,
    output logic        flush,
    output logic [31:0] br_count,
    output logic [31:0] mispred_count
);

    logic        fd_is_br_s;
    logic        fd_is_jal_s;
    logic        x_br_s;
    logic        x_pred_taken_s;
    logic        bht_msb_s;
    logic [2:0]  pc_sel_s;
    logic        flush_s;
    logic        mispredict_s;
    logic        br_pred_taken_s;
    logic        unused_s;

    logic        pred_valid_q, pred_valid_d;
    logic        pred_taken_q, pred_taken_d;
    logic [31:0] br_count_q, br_count_d;
    logic [31:0] mispred_count_q, mispred_count_d;

    assign fd_is_br_s     = (fd_inst[6:0] == OPC_BRANCH);
    assign fd_is_jal_s    = (fd_inst[6:0] == OPC_JAL);
    assign x_br_s         = x_is_branch & ~x_is_jalr;
    assign x_pred_taken_s = pred_valid_q & pred_taken_q;

`ifdef FETCH_BHT_EN
    logic [1:0] bht_ctr_s;

    fetch_bht #(
        .IDX_BITS (BHT_IDX_BITS)
    ) u_bht (
        .clk        (clk),
        .rst        (rst),
        .rd_idx_i   (fd_pc[BHT_IDX_BITS+1:2]),
        .rd_ctr_o   (bht_ctr_s),
        .wr_en_i    (x_br_s & ~stall),
        .wr_idx_i   (x_pc[BHT_IDX_BITS+1:2]),
        .wr_taken_i (x_br_taken)
    );

    assign bht_msb_s = bht_ctr_s[1];
    assign unused_s  = ^{fd_inst[31:7], fd_pc, x_pc};
`else
    assign bht_msb_s = 1'b0;
    assign unused_s  = ^{fd_inst[31:7], fd_pc, x_pc, fd_pc[BHT_IDX_BITS+1:2]};
`endif

    // PC-select priority: X-stage redirects outrank anything decoded in F/D.
    always_comb begin
        pc_sel_s     = PC_SEL_PC4;
        flush_s      = 1'b0;
        mispredict_s = 1'b0;
        if (x_is_jalr) begin
            pc_sel_s = PC_SEL_JALR_X;
            flush_s  = 1'b1;
        end else if (x_is_branch) begin
            pc_sel_s     = PC_SEL_BR_RES;
            mispredict_s = x_br_taken ^ x_pred_taken_s;
            flush_s      = mispredict_s;
        end else if (fd_is_jal_s) begin
            pc_sel_s = PC_SEL_JAL;
        end else if (fd_is_br_s) begin
            pc_sel_s = PC_SEL_BR_PRED;
        end else begin
            pc_sel_s = PC_SEL_PC4;
        end
    end

    assign br_pred_taken_s = fd_is_br_s & ~flush_s & bht_msb_s;

    // Next-state for in-flight prediction and the CSR counters.
    always_comb begin
        pred_valid_d    = pred_valid_q;
        pred_taken_d    = pred_taken_q;
        br_count_d      = br_count_q;
        mispred_count_d = mispred_count_q;
        if (!stall) begin
            pred_valid_d = fd_is_br_s & ~flush_s;
            pred_taken_d = br_pred_taken_s;
            if (x_br_s) begin
                br_count_d = br_count_q + 32'd1;
            end else begin
                br_count_d = br_count_q;
            end
            if (x_br_s && mispredict_s) begin
                mispred_count_d = mispred_count_q + 32'd1;
            end else begin
                mispred_count_d = mispred_count_q;
            end
        end else begin
            pred_valid_d = pred_valid_q;
        end
    end

    // State registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pred_valid_q    <= 1'b0;
            pred_taken_q    <= 1'b0;
            br_count_q      <= 32'd0;
            mispred_count_q <= 32'd0;
        end else begin
            pred_valid_q    <= pred_valid_d;
            pred_taken_q    <= pred_taken_d;
            br_count_q      <= br_count_d;
            mispred_count_q <= mispred_count_d;
        end
    end

    assign pc_sel        = pc_sel_s;
    assign flush         = flush_s;
    assign mispredict    = mispredict_s;
    assign br_pred_taken = br_pred_taken_s;
    assign br_count      = br_count_q;
    assign mispred_count = mispred_count_q;

endmodule
